// File: rtl/ncl_sum_collector.sv
// Collects dual-rail NCL sum/carry wavefronts into a binary word with a valid/ready handshake.
// Optional watchdog enabled by defining NCL_COLLECT_TIMEOUT_EN.
module ncl_sum_collector #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] sum,
  input  logic [1:0]         carryout,
  output logic               ki,
  output logic [WIDTH:0]     result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               err,
  output logic               timeout
);

  localparam int NB = 2*WIDTH + 2;

  typedef enum logic [1:0] {
    FLUSH    = 2'd0,
    REQ_DATA = 2'd1,
    HOLD     = 2'd2,
    REQ_NULL = 2'd3
  } state_t;

  state_t          state_q;
  logic [NB-1:0]   sync1_q, sync2_q, prev_q;
  logic            ki_q;
  logic [WIDTH:0]  result_q;
  logic            result_valid_q;
  logic            err_q;

  logic            all_data, all_null, any_illegal;
  logic [WIDTH:0]  data_bits;
  logic            stable, stable_complete, stable_empty;
  logic            advance;
  logic            frozen;

  // Two-flop synchronizer, plus one more stage to compare consecutive samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {carryout, sum};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    all_data    = 1'b1;
    all_null    = 1'b1;
    any_illegal = 1'b0;
    data_bits   = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      unique case (sync2_q[2*i +: 2])
        2'b00: begin all_data = 1'b0; end
        2'b01: begin all_null = 1'b0; data_bits[i] = 1'b0; end
        2'b10: begin all_null = 1'b0; data_bits[i] = 1'b1; end
        default: begin all_data = 1'b0; all_null = 1'b0; any_illegal = 1'b1; end
      endcase
    end
  end

  assign stable          = (sync2_q == prev_q);
  assign stable_complete = stable & all_data;
  assign stable_empty    = stable & all_null;

  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      FLUSH:    advance = stable_empty;
      REQ_DATA: advance = stable_complete;
      HOLD:     advance = result_valid_q & result_ready;
      REQ_NULL: advance = stable_empty;
      default:  advance = 1'b0;
    endcase
  end

`ifdef NCL_COLLECT_TIMEOUT_EN
  localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_q;
  logic           timeout_q;

  // Counts idle cycles while waiting for a wavefront; saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (((state_q == REQ_DATA) || (state_q == REQ_NULL)) && !advance) begin
      if (wd_q != WDW'(TIMEOUT)) wd_q <= wd_q + 1'b1;
      if (wd_q == WDW'(TIMEOUT - 1)) timeout_q <= 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  assign frozen  = timeout_q;
  assign timeout = timeout_q;
`else
  assign frozen  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FLUSH;
      ki_q           <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      if (any_illegal) err_q <= 1'b1;
      if (advance && !frozen) begin
        unique case (state_q)
          FLUSH: begin
            state_q <= REQ_DATA;
            ki_q    <= 1'b1;
          end
          REQ_DATA: begin
            state_q        <= HOLD;
            result_q       <= data_bits;
            result_valid_q <= 1'b1;
          end
          HOLD: begin
            state_q        <= REQ_NULL;
            result_valid_q <= 1'b0;
            ki_q           <= 1'b0;
          end
          REQ_NULL: begin
            state_q <= REQ_DATA;
            ki_q    <= 1'b1;
          end
          default: begin
            state_q <= FLUSH;
            ki_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ki           = ki_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ncl_sum_collector.sv
// Directed self-checking bench for ncl_sum_collector (default build, watchdog compiled out).
module tb_ncl_sum_collector;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic [2*WIDTH-1:0] sum;
  logic [1:0]         carryout;
  logic               ki;
  logic [WIDTH:0]     result;
  logic               result_valid;
  logic               result_ready;
  logic               err;
  logic               timeout;

  int checks   = 0;
  int failures = 0;

  ncl_sum_collector #(.WIDTH(WIDTH), .TIMEOUT(255)) dut (
    .clk          (clk),
    .reset        (reset),
    .sum          (sum),
    .carryout     (carryout),
    .ki           (ki),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .err          (err),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*WIDTH+1:0] encode(input logic [WIDTH:0] v);
    logic [2*WIDTH+1:0] e;
    e = '0;
    for (int i = 0; i <= WIDTH; i++) e[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return e;
  endfunction

  task automatic apply(input logic [2*WIDTH+1:0] v);
    {carryout, sum} = v;
  endtask

  // n = number of negedges until ki==1, or -1 if the budget expires.
  task automatic wait_ki1(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (ki === 1'b1) begin n = c; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin n = c; break; end
    end
  endtask

  logic [2*WIDTH+1:0] enc, cur;
  int n;

  initial begin
    reset = 1'b1;
    result_ready = 1'b0;
    apply('0);
    repeat (3) @(negedge clk);
    check("rst_ki", ki, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_err", err, 0);
    check("rst_timeout", timeout, 0);

    reset = 1'b0;
    wait_ki1(4, n);
    check("flush_to_req_data", (n > 0), 1);

    // Word 0x15A with ready already high: one-cycle valid pulse.
    result_ready = 1'b1;
    apply(encode(9'h15A));
    wait_valid(10, n);
    check("cap1_latency", n, 4);
    check("cap1_result", result, 9'h15A);
    check("cap1_ki", ki, 1);
    @(negedge clk);
    check("cap1_valid_drop", result_valid, 0);
    check("cap1_ki_drop", ki, 0);

    // Backpressure: ready low for 10 cycles, NULL arriving during HOLD is ignored.
    apply('0);
    wait_ki1(8, n);
    check("null_to_req_data", (n > 0), 1);
    result_ready = 1'b0;
    apply(encode(9'h15A));
    wait_valid(10, n);
    check("cap2_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", result_valid, 1);
      check("bp_ki", ki, 1);
      check("bp_result", result, 9'h15A);
      if (i == 4) apply('0);
    end
    check("bp_no_err", err, 0);
    result_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", result_valid, 0);
    check("bp_release_ki", ki, 0);
    @(negedge clk);
    check("bp_null_reqdata", ki, 1);

    // Skewed arrival: one digit becomes DATA per cycle.
    enc = encode(9'h0A5);
    cur = '0;
    for (int k = 0; k <= WIDTH; k++) begin
      cur[2*k +: 2] = enc[2*k +: 2];
      apply(cur);
      @(negedge clk);
      check("skew_no_capture", result_valid, 0);
    end
    wait_valid(10, n);
    check("skew_latency", n, 3);
    check("skew_result", result, 9'h0A5);
    @(negedge clk);
    check("skew_ki_drop", ki, 0);

    // Illegal digit 3.
    apply('0);
    wait_ki1(8, n);
    check("null_to_req_data2", (n > 0), 1);
    cur = encode(9'h1FF);
    cur[7:6] = 2'b11;
    apply(cur);
    repeat (2) @(negedge clk);
    check("err_not_yet", err, 0);
    @(negedge clk);
    check("err_set", err, 1);
    repeat (8) @(negedge clk);
    check("err_no_capture", result_valid, 0);
    check("err_ki_still_1", ki, 1);
    cur[7:6] = 2'b10;
    apply(cur);
    wait_valid(10, n);
    check("err_fixed_latency", n, 4);
    check("err_fixed_result", result, 9'h1FF);
    check("err_sticky", err, 1);

    // Partial vector held: no transition, no timeout in this build.
    apply('0);
    wait_ki1(10, n);
    check("null_to_req_data3", (n > 0), 1);
    cur = encode(9'h0F0);
    cur[2*WIDTH+1:8] = '0;
    apply(cur);
    repeat (30) @(negedge clk);
    check("partial_no_valid", result_valid, 0);
    check("partial_ki", ki, 1);
    check("partial_timeout", timeout, 0);

    // Reset in the middle of a held handshake.
    result_ready = 1'b0;
    apply(encode(9'h0C3));
    wait_valid(10, n);
    check("cap3_latency", n, 4);
    check("cap3_result", result, 9'h0C3);
    reset = 1'b1;
    apply('0);
    @(negedge clk);
    check("midrst_valid", result_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_err", err, 0);
    check("midrst_ki", ki, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ki1(4, n);
    check("midrst_reflush", (n > 0), 1);
    check("midrst_no_valid", result_valid, 0);
    check("midrst_result_zero", result, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
